// File: rtl/r4booth_digit_accumulator.sv
// Digit-serial radix-4 modified-Booth decoder: captures a signed multiplicand, accepts one recoded
// digit per handshake (LSB first) and returns the signed 2*WIDTH product.
module r4booth_digit_accumulator #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 start_ready_o,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic                 digit_valid_i,
    output logic                 digit_ready_o,
    input  logic                 mul1x_i,
    input  logic                 mul2x_i,
    input  logic                 mulsign_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 err_o
);

    localparam int NDIG = WIDTH / 2;
    localparam int AW   = 2 * WIDTH + 2;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Both magnitude selects at once has no meaning in the bit-pair table.
    function automatic logic digit_illegal(input logic m1, input logic m2);
        digit_illegal = m1 & m2;
    endfunction

    // Signed contribution of one digit given the current 4^k-weighted multiplicand.
    // Zero magnitude yields zero regardless of sign, so -0 never adds -M.
    function automatic logic [AW-1:0] digit_term(input logic [AW-1:0] weight,
                                                 input logic m1,
                                                 input logic m2,
                                                 input logic neg);
        logic [AW-1:0] mag;
        case ({m2, m1})
            2'b01:   mag = weight;
            2'b10:   mag = {weight[AW-2:0], 1'b0};
            default: mag = {AW{1'b0}};
        endcase
        if (neg) begin
            digit_term = {AW{1'b0}} - mag;
        end else begin
            digit_term = mag;
        end
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [AW-1:0]         weight_r;
    logic [AW-1:0]         acc_r;
    logic [CW-1:0]         cnt_r;
    logic                  err_r;
    logic [2*WIDTH-1:0]    result_r;
    logic                  err_out_r;
    logic                  result_valid_r;

    logic                  digit_fire_s;
    logic                  last_digit_s;
    logic                  illegal_s;
    logic [AW-1:0]         term_s;
    logic [AW-1:0]         acc_sum_s;

    // Handshake qualification and the per-digit arithmetic.
    always_comb begin
        digit_fire_s = digit_valid_i & (state_r == ST_ACCUM);
        last_digit_s = (cnt_r == LAST_DIG);
        illegal_s    = digit_illegal(mul1x_i, mul2x_i);
        term_s       = digit_term(weight_r, mul1x_i, mul2x_i, mulsign_i);
        acc_sum_s    = acc_r + term_s;
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (digit_fire_s && last_digit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (result_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: weight shifts by two bits per accepted digit so no barrel shifter is needed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            weight_r       <= {AW{1'b0}};
            acc_r          <= {AW{1'b0}};
            cnt_r          <= {CW{1'b0}};
            err_r          <= 1'b0;
            result_r       <= {(2*WIDTH){1'b0}};
            err_out_r      <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        weight_r <= {{(AW-WIDTH){multiplicand_i[WIDTH-1]}}, multiplicand_i};
                        acc_r    <= {AW{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        err_r    <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (digit_fire_s) begin
                        acc_r    <= acc_sum_s;
                        weight_r <= {weight_r[AW-3:0], 2'b00};
                        cnt_r    <= cnt_r + CW'(1'b1);
                        err_r    <= err_r | illegal_s;
                        if (last_digit_s) begin
                            result_r       <= acc_sum_s[2*WIDTH-1:0];
                            err_out_r      <= err_r | illegal_s;
                            result_valid_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (result_ready_i) begin
                        result_valid_r <= 1'b0;
                    end
                end
                default: begin
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready_o  = (state_r == ST_IDLE);
    assign digit_ready_o  = (state_r == ST_ACCUM);
    assign result_valid_o = result_valid_r;
    assign result_o       = result_r;
    assign err_o          = err_out_r;

endmodule

// File: tb/tb_r4booth_digit_accumulator.sv
// Self-checking bench for r4booth_digit_accumulator (WIDTH=8): directed cases plus randomized
// operations checked against an integer-arithmetic reference.
module tb_r4booth_digit_accumulator;

    localparam int WIDTH = 8;
    localparam int NDIG  = WIDTH / 2;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic                start_ready_o;
    logic [WIDTH-1:0]    multiplicand_i;
    logic                digit_valid_i;
    logic                digit_ready_o;
    logic                mul1x_i;
    logic                mul2x_i;
    logic                mulsign_i;
    logic                result_valid_o;
    logic                result_ready_i;
    logic [2*WIDTH-1:0]  result_o;
    logic                err_o;

    int n_checks = 0;
    int n_pass   = 0;

    r4booth_digit_accumulator #(.WIDTH(WIDTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .start_ready_o  (start_ready_o),
        .multiplicand_i (multiplicand_i),
        .digit_valid_i  (digit_valid_i),
        .digit_ready_o  (digit_ready_o),
        .mul1x_i        (mul1x_i),
        .mul2x_i        (mul2x_i),
        .mulsign_i      (mulsign_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Digit codes are {sign, mul2x, mul1x}; digit k lives in bits [3k+2:3k].
    function automatic logic [15:0] model_product(input logic [7:0] m, input logic [11:0] dig);
        longint x;
        longint w;
        longint p;
        int d;
        logic [2:0] c;
        x = 0;
        w = 1;
        for (int k = 0; k < NDIG; k++) begin
            c = dig[3*k +: 3];
            if (c[0] && !c[1]) d = 1;
            else if (c[1] && !c[0]) d = 2;
            else d = 0;
            if (c[2]) d = -d;
            x = x + longint'(d) * w;
            w = w * 4;
        end
        p = longint'($signed(m)) * x;
        return p[15:0];
    endfunction

    function automatic logic model_err(input logic [11:0] dig);
        logic e;
        e = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (dig[3*k +: 2] == 2'b11) e = 1'b1;
        end
        return e;
    endfunction

    // Standard bit-pair recoding of a multiplier, bit -1 = 0.
    function automatic logic [11:0] recode(input logic [7:0] x);
        logic [8:0]  xe;
        logic [2:0]  c;
        logic [11:0] dig;
        xe = {x, 1'b0};
        dig = 12'h000;
        for (int k = 0; k < NDIG; k++) begin
            case (xe[2*k +: 3])
                3'b001, 3'b010: c = 3'b001;
                3'b011:         c = 3'b010;
                3'b100:         c = 3'b110;
                3'b101, 3'b110: c = 3'b101;
                3'b111:         c = 3'b100;
                default:        c = 3'b000;
            endcase
            dig[3*k +: 3] = c;
        end
        return dig;
    endfunction

    function automatic logic [15:0] signed_mul(input logic [7:0] m, input logic [7:0] x);
        longint p;
        p = longint'($signed(m)) * longint'($signed(x));
        return p[15:0];
    endfunction

    task automatic run_op(input logic [7:0] m, input logic [11:0] dig, input logic [15:0] exp_res,
                          input logic exp_err, input int gap_pct, input int hold, input bit chk_lat);
        int  waited;
        int  g;
        bit  seen;
        check_eq("idle_start_ready", 64'(start_ready_o), 64'd1);
        start_i = 1'b1;
        multiplicand_i = m;
        digit_valid_i = 1'b1;
        {mulsign_i, mul2x_i, mul1x_i} = 3'($urandom);
        @(negedge clk);
        start_i = 1'b0;
        multiplicand_i = 8'($urandom);
        digit_valid_i = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if ($urandom_range(99) < gap_pct) begin
                g = $urandom_range(3, 1);
                repeat (g) begin
                    digit_valid_i = 1'b0;
                    start_i = 1'($urandom);
                    {mulsign_i, mul2x_i, mul1x_i} = 3'($urandom);
                    @(negedge clk);
                end
            end
            check_eq("accum_digit_ready", 64'(digit_ready_o), 64'd1);
            check_eq("accum_valid_low", 64'(result_valid_o), 64'd0);
            start_i = 1'($urandom);
            digit_valid_i = 1'b1;
            {mulsign_i, mul2x_i, mul1x_i} = dig[3*k +: 3];
            @(negedge clk);
        end
        digit_valid_i = 1'b0;
        start_i = 1'b0;
        waited = 0;
        seen = result_valid_o;
        while (!seen && waited < 20) begin
            @(negedge clk);
            waited++;
            seen = result_valid_o;
        end
        check_eq("result_timeout", 64'(seen), 64'd1);
        if (chk_lat) check_eq("result_latency", 64'(waited), 64'd0);
        repeat (hold) begin
            check_eq("hold_valid", 64'(result_valid_o), 64'd1);
            check_eq("hold_result", 64'(result_o), 64'(exp_res));
            check_eq("hold_err", 64'(err_o), 64'(exp_err));
            check_eq("hold_start_ready", 64'(start_ready_o), 64'd0);
            check_eq("hold_digit_ready", 64'(digit_ready_o), 64'd0);
            result_ready_i = 1'b0;
            start_i = 1'b1;
            digit_valid_i = 1'b1;
            {mulsign_i, mul2x_i, mul1x_i} = 3'($urandom);
            @(negedge clk);
        end
        check_eq("done_valid", 64'(result_valid_o), 64'd1);
        check_eq("done_result", 64'(result_o), 64'(exp_res));
        check_eq("done_err", 64'(err_o), 64'(exp_err));
        result_ready_i = 1'b1;
        start_i = 1'b0;
        digit_valid_i = 1'b0;
        @(negedge clk);
        result_ready_i = 1'b0;
        check_eq("post_valid_low", 64'(result_valid_o), 64'd0);
        check_eq("post_start_ready", 64'(start_ready_o), 64'd1);
        check_eq("post_result_held", 64'(result_o), 64'(exp_res));
        check_eq("post_err_held", 64'(err_o), 64'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  m;
        logic [7:0]  x;
        logic [11:0] dig;
        logic [15:0] exp_res;
        logic        exp_err;

        rst_i = 1'b1;
        start_i = 1'b0;
        multiplicand_i = 8'h00;
        digit_valid_i = 1'b0;
        {mulsign_i, mul2x_i, mul1x_i} = 3'b000;
        result_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check_eq("rst_start_ready", 64'(start_ready_o), 64'd1);
        check_eq("rst_digit_ready", 64'(digit_ready_o), 64'd0);
        check_eq("rst_valid", 64'(result_valid_o), 64'd0);
        check_eq("rst_result", 64'(result_o), 64'd0);
        check_eq("rst_err", 64'(err_o), 64'd0);

        // X=5: +1,+1,0,0 back-to-back with latency check
        run_op(8'h03, {3'b000, 3'b000, 3'b001, 3'b001}, 16'h000F, 1'b0, 0, 0, 1'b1);
        // X=-128: 0,0,0,-2
        run_op(8'h80, {3'b110, 3'b000, 3'b000, 3'b000}, 16'h4000, 1'b0, 0, 0, 1'b1);
        // X=-1: -1 then three negative zeros
        run_op(8'h07, {3'b100, 3'b100, 3'b100, 3'b101}, 16'hFFF9, 1'b0, 0, 0, 1'b1);
        // gaps plus a long result stall, with start/digits driven during DONE
        x = 8'h9B;
        run_op(8'h2D, recode(x), signed_mul(8'h2D, x), 1'b0, 70, 5, 1'b0);
        // illegal digit 2, then a clean operation clears err
        run_op(8'h05, {3'b010, 3'b011, 3'b000, 3'b001}, 16'h0285, 1'b1, 0, 1, 1'b0);
        run_op(8'h05, {3'b000, 3'b000, 3'b000, 3'b001}, 16'h0005, 1'b0, 0, 0, 1'b0);

        // reset after two accepted digits
        start_i = 1'b1;
        multiplicand_i = 8'h09;
        @(negedge clk);
        start_i = 1'b0;
        digit_valid_i = 1'b1;
        {mulsign_i, mul2x_i, mul1x_i} = 3'b001;
        @(negedge clk);
        {mulsign_i, mul2x_i, mul1x_i} = 3'b010;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        digit_valid_i = 1'b0;
        check_eq("mid_rst_start_ready", 64'(start_ready_o), 64'd1);
        check_eq("mid_rst_digit_ready", 64'(digit_ready_o), 64'd0);
        check_eq("mid_rst_valid", 64'(result_valid_o), 64'd0);
        check_eq("mid_rst_result", 64'(result_o), 64'd0);
        check_eq("mid_rst_err", 64'(err_o), 64'd0);
        run_op(8'hFE, {3'b000, 3'b000, 3'b001, 3'b101}, 16'hFFFA, 1'b0, 0, 0, 1'b1);

        // randomized: alternate true recodings and arbitrary digit streams
        for (int i = 0; i < 40; i++) begin
            m = 8'($urandom);
            if (i % 2 == 0) begin
                x = 8'($urandom);
                dig = recode(x);
                exp_res = signed_mul(m, x);
                exp_err = 1'b0;
            end else begin
                dig = 12'($urandom);
                exp_res = model_product(m, dig);
                exp_err = model_err(dig);
            end
            run_op(m, dig, exp_res, exp_err, 40, $urandom_range(3, 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
